multi_port_byte_memory: RTL and testbench
=========================================

# multi_port_byte_memory

Parametrised byte-lane data memory: one write port and NUM_READ_PORTS independent synchronous read ports, all on one clock. Supports word, halfword and byte stores and loads with per-port sign/zero extension. Detects misaligned accesses and zero-fills its contents after reset. Serves as the data/instruction memory for the next-generation MIPS datapath, where several consumers (fetch, load unit, debug) read concurrently.

## Interface
- ADDRESS_WIDTH, 8: byte-address width; depth = 2**(ADDRESS_WIDTH-2) words
- NUM_READ_PORTS, 2: number of read ports, 1..4
- clock_in  in  1  single clock, all logic on rising edge
- reset_in  in  1  synchronous, active-high reset
- write_in  in  1  store request
- write_mode_in  in  2  store size: 0x word, 10 half, 11 byte
- write_address_in  in  ADDRESS_WIDTH  store byte address
- write_data_in  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- read_en_in  in  NUM_READ_PORTS  per-port load request
- read_mode_in  in  2*NUM_READ_PORTS  per-port load size, same encoding
- read_unsigned_in  in  NUM_READ_PORTS  1 = zero-extend, 0 = sign-extend
- read_address_in  in  ADDRESS_WIDTH*NUM_READ_PORTS  per-port byte address
- read_data_out  out  32*NUM_READ_PORTS  per-port load result, right-aligned and extended
- read_valid_out  out  NUM_READ_PORTS  read_data_out holds a completed load
- read_misaligned_out  out  NUM_READ_PORTS  load was rejected as misaligned
- write_misaligned_out  out  1  store was rejected as misaligned
- ready_out  out  1  clear sweep finished; requests are accepted

## Operation
- Four 8-bit banks. Bank k holds byte lane k; word index = address[ADDRESS_WIDTH-1:2].
- FSM states: CLEAR and RUN. Reset enters CLEAR with counter = 0.
- CLEAR: writes zero to word[counter] in all banks, then increments the counter. After word DEPTH-1 it moves to RUN. While in CLEAR, ready_out = 0 and all requests are ignored (no write, valid = 0, error flags = 0).
- RUN: ready_out = 1. Stays in RUN until reset.
- Alignment rules: halfword requires address[0] = 0; word requires address[1:0] = 0; bytes are always aligned.
- Store in RUN:
  - Word: writes all four lanes.
  - Half: writes lanes {3,2} if address[1] = 1, else lanes {1,0}, with data[15:8] on the upper lane.
  - Byte: writes lane address[1:0] with data[7:0].
  - Misaligned: the write is suppressed and write_misaligned_out = 1 on the next cycle.
- Load in RUN, per port:
  - Reads the addressed word and selects the lane(s) the same way as a store.
  - Result is right-aligned and extended to 32 bits per read_unsigned_in.
  - Misaligned: read_valid_out = 0, read_misaligned_out = 1, read_data_out = 0.
- A port with read_en_in = 0 gives read_valid_out = 0 and read_data_out = 0 on the next cycle.
- All read ports are independent; the same address on every port is legal.
- Read and write to the same word in the same cycle: read returns the pre-write contents (read-first), unless the bypass feature is compiled in.
- Reset mid-sweep or mid-operation restarts CLEAR from word 0. Memory contents are only guaranteed zero once ready_out = 1.

## Timing
- Load latency is 1 cycle: request sampled at edge n; data, valid and error flags are registered and visible after edge n. They hold for exactly one cycle unless the request repeats.
- Store takes effect at edge n; a load issued at edge n+1 sees it.
- write_misaligned_out is a one-cycle pulse after the offending edge.
- CLEAR lasts exactly DEPTH cycles; ready_out rises on the edge that completes word DEPTH-1 (64 cycles for ADDRESS_WIDTH = 8).
- Reset values:
  - FSM in CLEAR, counter 0.
  - ready_out 0.
  - read_data_out all 0, read_valid_out all 0.
  - read_misaligned_out all 0, write_misaligned_out 0.

## Configuration
- MULTI_PORT_BYTE_MEMORY_BYPASS_EN defined: a same-cycle read of the word being written returns the merged new value (write-first). The merge is per lane: only the written lanes come from write_data_in, all other lanes come from memory.
- Macro undefined: read-first behaviour as above; no forwarding logic is present.

## Structure
- Package multi_port_byte_memory_pkg holds:
  - mem_mode_t: MEM_WORD = 2'b00, MEM_HALF = 2'b10, MEM_BYTE = 2'b11; 2'b01 decodes as word.
  - mem_state_t: CLEAR, RUN.
  - Function is_aligned(mode, addr[1:0]).
  - Function extract_load(word, mode, addr[1:0], unsigned).
- One sub-module, byte_lane_bank: a single 8-bit lane with one write port, a write enable and NUM_READ_PORTS registered read ports. It is instantiated four times.

## Test plan
- Reset, count cycles -> ready_out = 0 for 64 cycles, then 1. A load issued during CLEAR -> valid = 0. Every word read back after the sweep = 0.
- Store word 0x8899AABB at 0x10, then load byte at 0x11 with unsigned = 0 -> 0xFFFFFFAA. Same load with unsigned = 1 -> 0x000000AA. Load half at 0x12 signed -> 0xFFFF8899.
- Store byte 0x5A at 0x23, then load word at 0x20 on both ports simultaneously -> both 0x5A000000, valid = 1.
- Store half at 0x05 -> write_misaligned_out pulses and memory is unchanged. Load word at 0x02 -> read_misaligned_out = 1, valid = 0, data = 0.
- Word at 0x30 holds 0x11111111; store word 0x22222222 and load 0x30 in the same cycle -> 0x11111111 without the macro, 0x22222222 with MULTI_PORT_BYTE_MEMORY_BYPASS_EN.
- Assert reset at cycle 30 of CLEAR -> sweep restarts; ready_out rises 64 cycles after reset deasserts.

Source files
------------

// File: rtl/multi_port_byte_memory_pkg.sv
// multi_port_byte_memory_pkg: modes, FSM states and lane helpers for the byte-lane memory
package multi_port_byte_memory_pkg;
  typedef enum logic [1:0] {MEM_WORD = 2'b00, MEM_HALF = 2'b10, MEM_BYTE = 2'b11} mem_mode_t;
  typedef enum logic {CLEAR, RUN} mem_state_t;
  function automatic logic is_aligned(input logic [1:0] mode, input logic [1:0] addr);
    return mode == MEM_BYTE ? 1'b1 : mode == MEM_HALF ? ~addr[0] : addr == 2'b00;
  endfunction
  function automatic logic [3:0] store_lanes(input logic [1:0] mode, input logic [1:0] addr);
    return mode == MEM_BYTE ? 4'b0001 << addr : mode == MEM_HALF ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  endfunction
  function automatic logic [31:0] store_data(input logic [1:0] mode, input logic [31:0] data);
    return mode == MEM_BYTE ? {4{data[7:0]}} : mode == MEM_HALF ? {2{data[15:0]}} : data;
  endfunction
  function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] mode,
                                               input logic [1:0] addr, input logic uns);
    logic [31:0] s;
    logic [15:0] h;
    s = word >> {addr, 3'b000};
    h = addr[1] ? word[31:16] : word[15:0];
    return mode == MEM_BYTE ? {{24{~uns & s[7]}}, s[7:0]} :
           mode == MEM_HALF ? {{16{~uns & h[15]}}, h} : word;
  endfunction
endpackage

// File: rtl/multi_port_byte_memory_byte_lane_bank.sv
// byte_lane_bank: one 8-bit lane, one write port, registered read ports
module byte_lane_bank #(
  parameter int WW = 6,
  parameter int NUM_READ_PORTS = 2
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [WW-1:0]                waddr,
  input  logic [7:0]                   wdata,
  input  logic [NUM_READ_PORTS*WW-1:0] raddr,
  output logic [NUM_READ_PORTS*8-1:0]  rdata
);
  logic [7:0] mem [2**WW];
  // write lane and read all ports; reads see pre-write contents
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    for (int p = 0; p < NUM_READ_PORTS; p++) rdata[8*p +: 8] <= mem[raddr[WW*p +: WW]];
  end
endmodule

// File: rtl/multi_port_byte_memory.sv
// multi_port_byte_memory: byte-lane memory, one store port, N load ports; MULTI_PORT_BYTE_MEMORY_BYPASS_EN enables write-first forwarding
module multi_port_byte_memory
  import multi_port_byte_memory_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int NUM_READ_PORTS = 2
) (
  input  logic                                clock_in,
  input  logic                                reset_in,
  input  logic                                write_in,
  input  logic [1:0]                          write_mode_in,
  input  logic [ADDRESS_WIDTH-1:0]            write_address_in,
  input  logic [31:0]                         write_data_in,
  input  logic [NUM_READ_PORTS-1:0]           read_en_in,
  input  logic [2*NUM_READ_PORTS-1:0]         read_mode_in,
  input  logic [NUM_READ_PORTS-1:0]           read_unsigned_in,
  input  logic [ADDRESS_WIDTH*NUM_READ_PORTS-1:0] read_address_in,
  output logic [32*NUM_READ_PORTS-1:0]        read_data_out,
  output logic [NUM_READ_PORTS-1:0]           read_valid_out,
  output logic [NUM_READ_PORTS-1:0]           read_misaligned_out,
  output logic                                write_misaligned_out,
  output logic                                ready_out
);
  localparam int WW = ADDRESS_WIDTH - 2;
  localparam int NP = NUM_READ_PORTS;
  mem_state_t state_q, state_d;
  logic [WW-1:0] count_q, count_d;
  logic clearing, wr_ok, wmis_q;
  logic [3:0] lanes;
  logic [WW-1:0] bank_waddr;
  logic [31:0] bank_wdata;
  logic [NP*WW-1:0] raddr_w;
  logic [3:0][NP*8-1:0] bank_rd;
  logic [NP-1:0] v_q, mis_q, uns_q, rd_ok;
  logic [NP-1:0][1:0] mode_q, off_q;
  assign clearing = state_q == CLEAR;
  assign wr_ok = ~clearing & write_in & is_aligned(write_mode_in, write_address_in[1:0]);
  assign lanes = clearing ? 4'hf : wr_ok ? store_lanes(write_mode_in, write_address_in[1:0]) : 4'h0;
  assign bank_waddr = clearing ? count_q : write_address_in[ADDRESS_WIDTH-1:2];
  assign bank_wdata = clearing ? 32'h0 : store_data(write_mode_in, write_data_in);
  assign ready_out = ~clearing;
  assign read_valid_out = v_q;
  assign read_misaligned_out = mis_q;
  assign write_misaligned_out = wmis_q;
  // sweep state and clear counter
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q <= CLEAR;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end
  // clear sweep walks every word once, then stays in RUN
  always_comb begin
    state_d = (clearing && &count_q) ? RUN : state_q;
    count_d = clearing ? count_q + 1'b1 : count_q;
  end
  // per-port word index and alignment check
  always_comb begin
    raddr_w = '0;
    rd_ok = '0;
    for (int p = 0; p < NP; p++) begin
      raddr_w[WW*p +: WW] = read_address_in[ADDRESS_WIDTH*p+2 +: WW];
      rd_ok[p] = is_aligned(read_mode_in[2*p +: 2], read_address_in[ADDRESS_WIDTH*p +: 2]);
    end
  end
  for (genvar k = 0; k < 4; k++) begin : g_bank
    byte_lane_bank #(.WW(WW), .NUM_READ_PORTS(NP)) u_bank (
      .clk(clock_in),
      .we(lanes[k]),
      .waddr(bank_waddr),
      .wdata(bank_wdata[8*k +: 8]),
      .raddr(raddr_w),
      .rdata(bank_rd[k])
    );
  end
  // load status and lane-select context follow the bank read by one cycle
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      v_q <= '0;
      mis_q <= '0;
      wmis_q <= 1'b0;
    end else begin
      v_q <= {NP{~clearing}} & read_en_in & rd_ok;
      mis_q <= {NP{~clearing}} & read_en_in & ~rd_ok;
      wmis_q <= ~clearing & write_in & ~is_aligned(write_mode_in, write_address_in[1:0]);
    end
    uns_q <= read_unsigned_in;
    for (int p = 0; p < NP; p++) begin
      mode_q[p] <= read_mode_in[2*p +: 2];
      off_q[p] <= read_address_in[ADDRESS_WIDTH*p +: 2];
    end
  end
`ifdef MULTI_PORT_BYTE_MEMORY_BYPASS_EN
  logic [NP-1:0] fwd_q;
  logic [3:0] fl_q;
  logic [31:0] fd_q;
  // remember which lanes a store wrote into the word each port read
  always_ff @(posedge clock_in) begin
    fl_q <= clearing ? 4'h0 : lanes;
    fd_q <= bank_wdata;
    for (int p = 0; p < NP; p++) fwd_q[p] <= raddr_w[WW*p +: WW] == write_address_in[ADDRESS_WIDTH-1:2];
  end
`endif
  // assemble each port's word, merge forwarded lanes, extract and extend
  always_comb begin
    read_data_out = '0;
    for (int p = 0; p < NP; p++) begin
      logic [31:0] w;
      w = '0;
      for (int k = 0; k < 4; k++) begin
        w[8*k +: 8] = bank_rd[k][8*p +: 8];
`ifdef MULTI_PORT_BYTE_MEMORY_BYPASS_EN
        w[8*k +: 8] = (fwd_q[p] & fl_q[k]) ? fd_q[8*k +: 8] : w[8*k +: 8];
`endif
      end
      read_data_out[32*p +: 32] = v_q[p] ? extract_load(w, mode_q[p], off_q[p], uns_q[p]) : 32'h0;
    end
  end
endmodule

// File: tb/tb_multi_port_byte_memory.sv
// tb_multi_port_byte_memory: randomized scoreboard bench against a word-array reference model
module tb_multi_port_byte_memory;
  localparam int AW = 8;
  localparam int NP = 2;
  localparam int DEPTH = 64;
  logic clk = 1'b0;
  logic reset_in = 1'b1;
  logic write_in = 1'b0;
  logic [1:0] write_mode_in = '0;
  logic [AW-1:0] write_address_in = '0;
  logic [31:0] write_data_in = '0;
  logic [NP-1:0] read_en_in = '0;
  logic [2*NP-1:0] read_mode_in = '0;
  logic [NP-1:0] read_unsigned_in = '0;
  logic [AW*NP-1:0] read_address_in = '0;
  logic [32*NP-1:0] read_data_out;
  logic [NP-1:0] read_valid_out, read_misaligned_out;
  logic write_misaligned_out, ready_out;

  always #5 clk = ~clk;

  multi_port_byte_memory #(.ADDRESS_WIDTH(AW), .NUM_READ_PORTS(NP)) dut (
    .clock_in(clk),
    .reset_in(reset_in),
    .write_in(write_in),
    .write_mode_in(write_mode_in),
    .write_address_in(write_address_in),
    .write_data_in(write_data_in),
    .read_en_in(read_en_in),
    .read_mode_in(read_mode_in),
    .read_unsigned_in(read_unsigned_in),
    .read_address_in(read_address_in),
    .read_data_out(read_data_out),
    .read_valid_out(read_valid_out),
    .read_misaligned_out(read_misaligned_out),
    .write_misaligned_out(write_misaligned_out),
    .ready_out(ready_out)
  );

  typedef struct packed {
    logic [NP*32-1:0] d;
    logic [NP-1:0] v;
    logic [NP-1:0] m;
    logic wm;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0;
  int errors = 0;
  int unsigned model [DEPTH];

  logic w_en;
  logic [1:0] w_mode;
  logic [7:0] w_addr;
  logic [31:0] w_data;
  logic [NP-1:0] r_en, r_uns;
  logic [1:0] r_mode [NP];
  logic [7:0] r_addr [NP];

  function automatic bit aligned_ok(input logic [1:0] m, input logic [7:0] a);
    if (m == 2'b11) return 1'b1;
    if (m == 2'b10) return (a % 2) == 0;
    return (a % 4) == 0;
  endfunction

  function automatic logic [31:0] load_model(input int unsigned w, input logic [1:0] m,
                                             input logic [7:0] a, input logic uns);
    int unsigned v;
    if (m == 2'b11) begin
      v = (w >> (8 * (a % 4))) & 32'hff;
      if (!uns && v >= 128) v = v | 32'hffffff00;
    end else if (m == 2'b10) begin
      v = (w >> (16 * ((a / 2) % 2))) & 32'hffff;
      if (!uns && v >= 32768) v = v | 32'hffff0000;
    end else v = w;
    return v;
  endfunction

  task automatic apply_store();
    int idx, sh;
    idx = w_addr / 4;
    if (w_mode == 2'b11) begin
      sh = 8 * (w_addr % 4);
      model[idx] = (model[idx] & ~(32'hff << sh)) | ((w_data & 32'hff) << sh);
    end else if (w_mode == 2'b10) begin
      sh = 16 * ((w_addr / 2) % 2);
      model[idx] = (model[idx] & ~(32'hffff << sh)) | ((w_data & 32'hffff) << sh);
    end else model[idx] = w_data;
  endtask

  task automatic idle_vars();
    w_en = 0; w_mode = 0; w_addr = 0; w_data = 0; r_en = 0; r_uns = 0;
    for (int p = 0; p < NP; p++) begin
      r_mode[p] = 0;
      r_addr[p] = 0;
    end
  endtask

  task automatic step();
    exp_t x;
    bit wa;
    write_in = w_en; write_mode_in = w_mode; write_address_in = w_addr; write_data_in = w_data;
    read_en_in = r_en; read_unsigned_in = r_uns;
    for (int p = 0; p < NP; p++) begin
      read_mode_in[2*p +: 2] = r_mode[p];
      read_address_in[AW*p +: AW] = r_addr[p];
    end
    @(posedge clk);
    x = '0;
    wa = w_en && aligned_ok(w_mode, w_addr);
`ifdef MULTI_PORT_BYTE_MEMORY_BYPASS_EN
    if (wa) apply_store();
`endif
    for (int p = 0; p < NP; p++) begin
      if (r_en[p] && aligned_ok(r_mode[p], r_addr[p])) begin
        x.v[p] = 1'b1;
        x.d[32*p +: 32] = load_model(model[r_addr[p] / 4], r_mode[p], r_addr[p], r_uns[p]);
      end else if (r_en[p]) x.m[p] = 1'b1;
    end
    x.wm = w_en && !wa;
`ifndef MULTI_PORT_BYTE_MEMORY_BYPASS_EN
    if (wa) apply_store();
`endif
    q.push_back(x);
    #1;
    write_in = 0;
    read_en_in = 0;
    idle_vars();
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Release reset and count cycles until ready, requiring loads to stay invalid meanwhile
  task automatic wait_ready();
    int n;
    n = 0;
    reset_in = 0;
    read_en_in = '1;
    read_mode_in = '0;
    read_address_in = '0;
    while (n < 200) begin
      @(posedge clk);
      #1;
      n++;
      check("clear_valid", 64'(read_valid_out), 64'(0));
      if (ready_out) break;
    end
    read_en_in = '0;
    check("ready_cycles", 64'(n), 64'(DEPTH));
    for (int i = 0; i < DEPTH; i++) model[i] = 0;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      for (int p = 0; p < NP; p++) begin
        checks++;
        if (read_data_out[32*p +: 32] !== e.d[32*p +: 32]) begin
          errors++;
          $display("FAIL port%0d data: got %h expected %h", p, read_data_out[32*p +: 32], e.d[32*p +: 32]);
        end
        checks++;
        if (read_valid_out[p] !== e.v[p]) begin
          errors++;
          $display("FAIL port%0d valid: got %b expected %b", p, read_valid_out[p], e.v[p]);
        end
        checks++;
        if (read_misaligned_out[p] !== e.m[p]) begin
          errors++;
          $display("FAIL port%0d misaligned: got %b expected %b", p, read_misaligned_out[p], e.m[p]);
        end
      end
      checks++;
      if (write_misaligned_out !== e.wm) begin
        errors++;
        $display("FAIL write_misaligned: got %b expected %b", write_misaligned_out, e.wm);
      end
    end
  end

  initial begin
    idle_vars();
    for (int i = 0; i < DEPTH; i++) model[i] = 0;
    reset_in = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(ready_out), 64'(0));
    check("rst_valid", 64'(read_valid_out), 64'(0));
    check("rst_data", 64'(read_data_out), 64'(0));
    check("rst_rmis", 64'(read_misaligned_out), 64'(0));
    check("rst_wmis", 64'(write_misaligned_out), 64'(0));
    wait_ready();
    for (int i = 0; i < DEPTH; i++) begin
      r_en = '1;
      for (int p = 0; p < NP; p++) r_addr[p] = 8'(((i + p * 17) % DEPTH) * 4);
      step();
    end
    w_en = 1; w_mode = 2'b00; w_addr = 8'h10; w_data = 32'h8899aabb; step();
    r_en = 2'b11; r_mode[0] = 2'b11; r_addr[0] = 8'h11; r_uns[0] = 0;
    r_mode[1] = 2'b11; r_addr[1] = 8'h11; r_uns[1] = 1; step();
    r_en = 2'b01; r_mode[0] = 2'b10; r_addr[0] = 8'h12; step();
    w_en = 1; w_mode = 2'b11; w_addr = 8'h23; w_data = 32'h0000005a; step();
    r_en = 2'b11; r_addr[0] = 8'h20; r_addr[1] = 8'h20; step();
    w_en = 1; w_mode = 2'b10; w_addr = 8'h05; w_data = 32'h0000ffff; step();
    r_en = 2'b11; r_addr[0] = 8'h02; r_addr[1] = 8'h04; step();
    w_en = 1; w_mode = 2'b00; w_addr = 8'h30; w_data = 32'h11111111; step();
    w_en = 1; w_mode = 2'b00; w_addr = 8'h30; w_data = 32'h22222222;
    r_en = 2'b11; r_addr[0] = 8'h30; r_addr[1] = 8'h30; step();
    w_en = 1; w_mode = 2'b11; w_addr = 8'h31; w_data = 32'h000000c3;
    r_en = 2'b11; r_addr[0] = 8'h30; r_mode[1] = 2'b10; r_addr[1] = 8'h30; step();
    r_en = 2'b01; r_addr[0] = 8'h30; step();
    for (int i = 0; i < 600; i++) begin
      w_en = 1'($urandom_range(0, 1));
      w_mode = 2'($urandom_range(0, 3));
      w_addr = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 31)) : 8'($urandom_range(0, 255));
      w_data = $urandom;
      for (int p = 0; p < NP; p++) begin
        r_en[p] = ($urandom_range(0, 3) != 0);
        r_uns[p] = 1'($urandom_range(0, 1));
        r_mode[p] = 2'($urandom_range(0, 3));
        r_addr[p] = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 31)) : 8'($urandom_range(0, 255));
      end
      step();
    end
    repeat (2) @(posedge clk);
    #1;
    reset_in = 1;
    @(posedge clk);
    #1;
    reset_in = 0;
    repeat (30) @(posedge clk);
    #1;
    check("mid_sweep_ready", 64'(ready_out), 64'(0));
    reset_in = 1;
    @(posedge clk);
    #1;
    wait_ready();
    for (int i = 0; i < 8; i++) begin
      r_en = '1;
      for (int p = 0; p < NP; p++) r_addr[p] = 8'((i + p * 8) * 4);
      step();
    end
    repeat (2) @(posedge clk);
    #1;
    check("queue_drained", 64'(q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
